// File: rtl/program_sequencer.sv
// Two-cycle fetch/execute sequencer for a 1-bit ICU: fetches 12-bit program words,
// forwards opcodes, and handles JMP/RTN through a small return stack and SKZ on rr.
module program_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [11:0] mem_data,
    input  logic        rr,
    output logic [7:0]  pc,
    output logic [3:0]  op,
    output logic [7:0]  io_addr,
    output logic        flag0,
    output logic        flagf,
    output logic        err
);

    // state | meaning
    // FETCH | wait for run, latch mem_data at pc into ir
    // EXEC  | present ir on op/io_addr, update pc and return stack
    // ERR   | return-stack fault, frozen until rst
    typedef enum logic [1:0] {FETCH, EXEC, ERR} state_t;

    localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int PW = SW + 1;
    localparam logic [PW-1:0] SP_FULL = PW'(STACK_DEPTH);

    state_t         state;
    logic [11:0]    ir;
    logic [PW-1:0]  sp;
    logic [7:0]     stack [STACK_DEPTH];

    logic [7:0]     pc_p1;
    logic [7:0]     pc_p2;
    logic [PW-1:0]  sp_m1;

    assign pc_p1 = pc + 8'd1;
    assign pc_p2 = pc + 8'd2;
    assign sp_m1 = sp - PW'(1);

    // op/io_addr/flags are loaded on the fetch edge so they are valid exactly during EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= 8'h00;
            ir      <= 12'h000;
            sp      <= '0;
            err     <= 1'b0;
            op      <= 4'h0;
            io_addr <= 8'h00;
            flag0   <= 1'b0;
            flagf   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (run) begin
                        ir      <= mem_data;
                        op      <= mem_data[11:8];
                        io_addr <= mem_data[7:0];
                        flag0   <= (mem_data[11:8] == 4'h0);
                        flagf   <= (mem_data[11:8] == 4'hF);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    op      <= 4'h0;
                    io_addr <= 8'h00;
                    flag0   <= 1'b0;
                    flagf   <= 1'b0;
                    state   <= FETCH;
                    case (ir[11:8])
                        4'hC: begin
                            if (sp == SP_FULL) begin
                                err   <= 1'b1;
                                state <= ERR;
                            end else begin
                                stack[sp[SW-1:0]] <= pc_p1;
                                sp                <= sp + PW'(1);
                                pc                <= ir[7:0];
                            end
                        end
                        4'hD: begin
                            if (sp == '0) begin
                                err   <= 1'b1;
                                state <= ERR;
                            end else begin
                                sp <= sp_m1;
                                pc <= stack[sp_m1[SW-1:0]];
                            end
                        end
                        4'hE:    pc <= rr ? pc_p1 : pc_p2;
                        default: pc <= pc_p1;
                    endcase
                end
                ERR: begin
                    state   <= ERR;
                    op      <= 4'h0;
                    io_addr <= 8'h00;
                    flag0   <= 1'b0;
                    flagf   <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a single-instruction vector table run from
// reset, followed by hand-written multi-cycle sequences (skip, call/return, faults, wrap).
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [11:0] mem_data;
    logic        rr;
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [7:0]  io_addr;
    logic        flag0;
    logic        flagf;
    logic        err;

    logic [11:0] mem [256];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign mem_data = mem[pc];

    program_sequencer #(.STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_data(mem_data), .rr(rr),
        .pc(pc), .op(op), .io_addr(io_addr), .flag0(flag0), .flagf(flagf), .err(err)
    );

    typedef struct {
        logic [11:0] word;
        logic        rr;
        logic [3:0]  op;
        logic [7:0]  io;
        logic        f0;
        logic        ff;
        logic [7:0]  npc;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'h100;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; rr = 1'b0;
        clear_mem();

        vecs[0] = '{12'h105, 1'b0, 4'h1, 8'h05, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[1] = '{12'h806, 1'b0, 4'h8, 8'h06, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[2] = '{12'h000, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
        vecs[3] = '{12'hF00, 1'b0, 4'hF, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{12'hE00, 1'b0, 4'hE, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0};
        vecs[5] = '{12'hE00, 1'b1, 4'hE, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[6] = '{12'hC40, 1'b0, 4'hC, 8'h40, 1'b0, 1'b0, 8'h40, 1'b0};
        vecs[7] = '{12'hD00, 1'b0, 4'hD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{12'hBAB, 1'b0, 4'hB, 8'hAB, 1'b0, 1'b0, 8'h01, 1'b0};

        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pc", pc, 8'h00);
        chk("reset_op", op, 4'h0);
        chk("reset_io", io_addr, 8'h00);
        chk("reset_err", err, 1'b0);
        chk("reset_flags", {flag0, flagf}, 2'b00);

        // single-instruction vectors from pc 0
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            mem[0] = vecs[v].word;
            do_reset();
            run = 1'b1;
            rr  = vecs[v].rr;
            tick();
            chk($sformatf("v%0d_op", v), op, vecs[v].op);
            chk($sformatf("v%0d_io", v), io_addr, vecs[v].io);
            chk($sformatf("v%0d_flags", v), {flag0, flagf}, {vecs[v].f0, vecs[v].ff});
            chk($sformatf("v%0d_pc_in_exec", v), pc, 8'h00);
            run = 1'b0;
            tick();
            chk($sformatf("v%0d_npc", v), pc, vecs[v].npc);
            chk($sformatf("v%0d_err", v), err, vecs[v].err);
            chk($sformatf("v%0d_idle_out", v), {op, io_addr, flag0, flagf}, 14'h0);
            rr = 1'b0;
        end

        // linear program; run dropped in EXEC must be ignored
        clear_mem();
        mem[0] = 12'h105; mem[1] = 12'h806;
        do_reset();
        run = 1'b1;
        tick();
        chk("lin_c2", {op, io_addr}, {4'h1, 8'h05});
        run = 1'b0;
        tick();
        chk("lin_pc1", pc, 8'h01);
        run = 1'b1;
        tick();
        chk("lin_c4", {op, io_addr}, {4'h8, 8'h06});
        tick();
        chk("lin_pc2", pc, 8'h02);

        // skip on zero at pc 3
        for (int r = 0; r < 2; r++) begin
            clear_mem();
            mem[3] = 12'hE00;
            do_reset();
            run = 1'b1;
            rr  = r[0];
            ticks(6);
            chk($sformatf("skz%0d_at3", r), pc, 8'h03);
            ticks(2);
            chk($sformatf("skz%0d_next", r), pc, r ? 8'h04 : 8'h05);
            rr = 1'b0;
        end

        // call / return
        clear_mem();
        mem[0] = 12'hC40; mem[8'h40] = 12'hD00;
        do_reset();
        run = 1'b1;
        ticks(2);
        chk("call_pc", pc, 8'h40);
        ticks(2);
        chk("ret_pc", pc, 8'h01);
        chk("ret_err", err, 1'b0);

        // stack overflow on 5th nested JMP
        clear_mem();
        mem[0] = 12'hC10; mem[8'h10] = 12'hC20; mem[8'h20] = 12'hC30;
        mem[8'h30] = 12'hC50; mem[8'h50] = 12'hC60;
        do_reset();
        run = 1'b1;
        ticks(8);
        chk("ovf_pc4", pc, 8'h50);
        chk("ovf_err_before", err, 1'b0);
        tick();
        chk("ovf_op_exec", {op, io_addr}, {4'hC, 8'h60});
        tick();
        chk("ovf_err", err, 1'b1);
        chk("ovf_pc_frozen", pc, 8'h50);
        ticks(4);
        chk("ovf_err_hold", {err, pc, op, io_addr, flag0, flagf}, {1'b1, 8'h50, 14'h0});
        do_reset();
        chk("ovf_rst", {err, pc}, {1'b0, 8'h00});

        // underflow pop, then a following good call must work after reset
        clear_mem();
        mem[0] = 12'hD00;
        do_reset();
        run = 1'b1;
        ticks(2);
        chk("unf_err", {err, pc}, {1'b1, 8'h00});
        mem[0] = 12'hC40; mem[8'h40] = 12'hD00;
        ticks(4);
        chk("unf_stuck", {err, pc, op}, {1'b1, 8'h00, 4'h0});
        do_reset();
        chk("unf_rst", err, 1'b0);
        ticks(4);
        chk("unf_after_rst_ret", {err, pc}, {1'b0, 8'h01});

        // hold in FETCH, then flagf at FF with pc wrap
        clear_mem();
        mem[0] = 12'hCFF; mem[8'hFF] = 12'hF00;
        do_reset();
        run = 1'b0;
        ticks(3);
        chk("hold", {pc, op}, 12'h000);
        run = 1'b1;
        ticks(2);
        chk("wrap_at_ff", pc, 8'hFF);
        tick();
        chk("flagf_on", {flagf, flag0, op}, {2'b10, 4'hF});
        tick();
        chk("flagf_off", flagf, 1'b0);
        chk("wrap_pc", pc, 8'h00);

        // FE+2 and FF+2 wraps through SKZ
        for (int s = 0; s < 2; s++) begin
            clear_mem();
            mem[0] = s ? 12'hCFF : 12'hCFE;
            mem[8'hFE] = 12'hE00; mem[8'hFF] = 12'hE00;
            do_reset();
            run = 1'b1; rr = 1'b0;
            ticks(4);
            chk($sformatf("skz_wrap%0d", s), pc, s ? 8'h01 : 8'h00);
        end

        // pushed return address wraps FF+1 -> 00
        clear_mem();
        mem[0] = 12'hCFF; mem[8'hFF] = 12'hC10; mem[8'h10] = 12'hD00;
        do_reset();
        run = 1'b1;
        ticks(6);
        chk("push_wrap", pc, 8'h00);

        // reset mid-EXEC cancels the JMP
        clear_mem();
        mem[0] = 12'hC40;
        do_reset();
        run = 1'b1;
        tick();
        chk("midexec_op", op, 4'hC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midexec_rst", {pc, op, io_addr}, 20'h0);
        mem[0] = 12'hD00;
        ticks(2);
        chk("midexec_no_push", err, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL provide these ports (clock and reset first):
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  1 = advance program; 0 = hold at next FETCH
- mem_data  input  12  program word at pc; [11:8] opcode, [7:0] operand
- rr  input  1  result register from the 1-bit ICU
- pc  output  8  program memory address
- op  output  4  opcode to ICU instruction input I
- io_addr  output  8  operand of the instruction in EXEC (I/O select)
- flag0  output  1  one-cycle pulse on executed opcode 4'h0
- flagf  output  1  one-cycle pulse on executed opcode 4'hF
- err  output  1  sticky return-stack fault
REQ-002 SHALL have one parameter: STACK_DEPTH, default 4, meaning return-stack entries (power of two, 2..8).

Function
REQ-003 SHALL implement FSM states FETCH, EXEC, ERR; two cycles per instruction.
REQ-004 FETCH: if run=1, SHALL latch mem_data into ir and go to EXEC; if run=0, SHALL stay in FETCH with pc held.
REQ-005 EXEC: SHALL drive op=ir[11:8] and io_addr=ir[7:0] for exactly one cycle, then go to FETCH (or ERR); run is ignored in EXEC.
REQ-006 Outside EXEC, op SHALL be 4'h0, io_addr SHALL be 8'h00, flag0=flagf=0.
REQ-007 Opcodes 4'h1-4'hB SHALL be forwarded on op; next pc=pc+1.
REQ-008 Opcode 4'hC (JMP): SHALL push pc+1 onto the return stack; next pc=ir[7:0].
REQ-009 Opcode 4'hD (RTN): SHALL pop the return stack; next pc=popped value.
REQ-010 Opcode 4'hE (SKZ): SHALL sample rr at the rising edge ending EXEC; rr=0 -> next pc=pc+2; rr=1 -> next pc=pc+1.
REQ-011 Opcodes 4'h0/4'hF SHALL assert flag0/flagf during EXEC; next pc=pc+1.
REQ-012 JMP/RTN/SKZ SHALL still be forwarded on op during EXEC; the ICU treats them as no-ops.
REQ-013 pc arithmetic SHALL be modulo 256: 8'hFF+1=8'h00, 8'hFE+2=8'h00, 8'hFF+2=8'h01; pushed return address wraps the same way.
REQ-014 Return stack: LIFO, STACK_DEPTH entries, pointer counts 0..STACK_DEPTH.
REQ-015 JMP with stack full SHALL not push, SHALL set err=1 and go to ERR.
REQ-016 RTN with stack empty SHALL set err=1 and go to ERR.
REQ-017 ERR: SHALL hold pc and drive op=4'h0, io_addr=0, no flags; exit only by rst.
REQ-018 A faulting JMP/RTN SHALL still present op for its EXEC cycle; the fault takes effect at the edge ending EXEC.
REQ-019 pc SHALL change only at the edge ending EXEC; mem_data is assumed valid combinationally from pc within the FETCH cycle.

Reset
REQ-020 rst=1 at a rising edge SHALL force: state FETCH, pc=8'h00, ir=12'h000, stack pointer 0, err=0, op=4'h0, io_addr=8'h00, flag0=flagf=0.
REQ-021 rst SHALL take priority over run and every state, including mid-EXEC and ERR; an interrupted instruction has no effect.
REQ-022 The first FETCH after rst deasserts SHALL use pc=8'h00.

Verification
REQ-023 Linear program: mem[0]=12'h105, mem[1]=12'h806, run=1 -> op=1, io_addr=5 in cycle 2; op=8, io_addr=6 in cycle 4; pc=2 after cycle 4.
REQ-024 SKZ: mem[3]=12'hE00, rr=0 -> next fetch pc=5; with rr=1 -> pc=4.
REQ-025 Call/return: mem[0]=12'hC40, mem[40h]=12'hD00 -> pc 0->40h->01; stack pointer 0->1->0.
REQ-026 Stack faults: five nested JMPs with STACK_DEPTH=4 -> err=1 after the 5th EXEC, pc frozen; separately, RTN at reset -> err=1; rst -> err=0, pc=0.
REQ-027 Hold/flags/wrap: run=0 for 3 cycles in FETCH -> pc and op stay 0; mem[FFh]=12'hF00 -> flagf pulses 1 cycle, next pc=00h.
